// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide unit owning the HI/LO register pair.
//   MULT/MULTU use radix-2 shift-add; DIV/DIVU use restoring division.
//   Each operation takes N RUN cycles plus one FIX cycle for sign correction.
//   Divide by zero completes in one cycle with a flag.
//
// Ports
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset
//   i_start     operation request, sampled only in IDLE
//   i_op        0 = multiply, 1 = divide
//   i_sign      1 = signed (two's complement), 0 = unsigned
//   i_a, i_b    operands, sampled on the accepting edge
//   i_wr_hi     MTHI write strobe (IDLE only)
//   i_wr_lo     MTLO write strobe (IDLE only)
//   i_wdata     MTHI/MTLO data
//   o_busy      operation in flight (RUN or FIX)
//   o_done      one-cycle pulse, HI/LO updated this cycle
//   o_div_zero  last divide had a zero divisor (held until next accepted start)
//   o_hi, o_lo  architectural HI/LO registers
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_op,
  input  logic         i_sign,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_wr_hi,
  input  logic         i_wr_lo,
  input  logic [N-1:0] i_wdata,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_div_zero,
  output logic [N-1:0] o_hi,
  output logic [N-1:0] o_lo
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Two's complement negation, modulo the operand width.
  function automatic logic [N-1:0] f_neg(input logic [N-1:0] x);
    f_neg = ~x + N'(1);
  endfunction

  // Two's complement negation of a full-width product.
  function automatic logic [2*N-1:0] f_neg2(input logic [2*N-1:0] x);
    f_neg2 = ~x + (2*N)'(1);
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_op;
  logic             r_neg_res;   // result (product/quotient) must be negated
  logic             r_neg_rem;   // remainder takes the dividend's sign
  logic             r_done;
  logic             r_div_zero;
  logic [N-1:0]     r_hi;
  logic [N-1:0]     r_lo;

  // Shared datapath: multiply keeps {upper partial product, multiplier},
  // divide keeps {remainder, quotient/dividend shift register}.
  logic [2*N-1:0]   r_acc;
  logic [N-1:0]     r_opb;

  logic             w_accept;
  logic             w_dz;
  logic             w_wr_ok;
  logic [N-1:0]     w_abs_a;
  logic [N-1:0]     w_abs_b;
  logic [N:0]       w_sum;
  logic [N:0]       w_trial;
  logic [2*N-1:0]   w_mul_nxt;
  logic [2*N-1:0]   w_div_nxt;
  logic [2*N-1:0]   w_prod;
  logic [N-1:0]     w_quot;
  logic [N-1:0]     w_rem;

  // Operand magnitudes at the accepting edge.
  assign w_abs_a = (i_sign && i_a[N-1]) ? f_neg(i_a) : i_a;
  assign w_abs_b = (i_sign && i_b[N-1]) ? f_neg(i_b) : i_b;

  // Shift-add step: carry out of the upper-half add shifts into the MSB.
  assign w_sum     = {1'b0, r_acc[2*N-1:N]} + {1'b0, (r_acc[0] ? r_opb : '0)};
  assign w_mul_nxt = {w_sum, r_acc[N-1:1]};

  // Restoring step: shifted remainder is below twice the divisor, so the
  // MSB of the (N+1)-bit difference is set exactly when the trial fails.
  assign w_trial   = {r_acc[2*N-1:N], r_acc[N-1]} - {1'b0, r_opb};
  assign w_div_nxt = w_trial[N] ? {r_acc[2*N-2:0], 1'b0}
                                : {w_trial[N-1:0], r_acc[N-2:0], 1'b1};

  // Sign correction applied in FIX.
  assign w_prod = r_neg_res ? f_neg2(r_acc) : r_acc;
  assign w_quot = r_neg_res ? f_neg(r_acc[N-1:0]) : r_acc[N-1:0];
  assign w_rem  = r_neg_rem ? f_neg(r_acc[2*N-1:N]) : r_acc[2*N-1:N];

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_dz        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_op && (i_b == '0)) begin
            w_dz = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // A start in IDLE (including divide by zero) takes priority over MTHI/MTLO.
  assign w_wr_ok = (r_state == S_IDLE) && !i_start;

  // Stage p0: control state, counter, HI/LO and status flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if (w_accept) begin
        r_cnt      <= '0;
        r_div_zero <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_dz) begin
        r_hi       <= i_a;
        r_lo       <= '1;
        r_div_zero <= 1'b1;
        r_done     <= 1'b1;
      end else if (r_state == S_FIX) begin
        r_done     <= 1'b1;
        r_div_zero <= 1'b0;
        if (r_op) begin
          r_hi <= w_rem;
          r_lo <= w_quot;
        end else begin
          r_hi <= w_prod[2*N-1:N];
          r_lo <= w_prod[N-1:0];
        end
      end else if (w_wr_ok) begin
        if (i_wr_hi) begin
          r_hi <= i_wdata;
        end
        if (i_wr_lo) begin
          r_lo <= i_wdata;
        end
      end
    end
  end

  // Stage p1: iterative datapath (data only, no reset needed)
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_op      <= i_op;
      r_neg_res <= i_sign && (i_a[N-1] ^ i_b[N-1]);
      r_neg_rem <= i_sign && i_a[N-1];
      r_opb     <= w_abs_b;
      r_acc     <= {{N{1'b0}}, w_abs_a};
    end else if (r_state == S_RUN) begin
      r_acc <= r_op ? w_div_nxt : w_mul_nxt;
    end
  end

  assign o_busy     = (r_state == S_RUN) || (r_state == S_FIX);
  assign o_done     = r_done;
  assign o_div_zero = r_div_zero;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//   Table-driven check of muldiv_unit: each vector is started, the unit is
//   observed for a fixed window, and done timing, busy length, HI/LO and the
//   divide-by-zero flag are compared against hand-computed values. Extra
//   hand-written sequences cover reset, MTHI/MTLO contention, start while
//   busy and reset mid-operation.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int N      = 32;
  localparam int WINDOW = 40;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          op;
  logic          sign;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          wr_hi;
  logic          wr_lo;
  logic [N-1:0]  wdata;
  logic          busy;
  logic          done;
  logic          div_zero;
  logic [N-1:0]  hi;
  logic [N-1:0]  lo;

  int checks;
  int errors;

  int            done_cyc;
  int            done_cnt;
  int            busy_cnt;
  logic [N-1:0]  cap_hi;
  logic [N-1:0]  cap_lo;
  logic          cap_dz;

  typedef struct {
    logic         op;
    logic         sign;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] exp_hi;
    logic [N-1:0] exp_lo;
    logic         exp_dz;
  } vec_t;

  vec_t vecs[12];

  muldiv_unit #(.N(N)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_op       (op),
    .i_sign     (sign),
    .i_a        (a),
    .i_b        (b),
    .i_wr_hi    (wr_hi),
    .i_wr_lo    (wr_lo),
    .i_wdata    (wdata),
    .o_busy     (busy),
    .o_done     (done),
    .o_div_zero (div_zero),
    .o_hi       (hi),
    .o_lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Starts one operation and watches cycles 1..WINDOW. Optionally re-pulses
  // start (with different operands) at cycle x_start, and drives MTLO at
  // cycle wrlo_cyc, checking lo is unchanged the cycle after.
  task automatic run_op(input logic v_op, input logic v_sign,
                        input logic [N-1:0] v_a, input logic [N-1:0] v_b,
                        input int x_start, input int wrlo_cyc);
    logic [N-1:0] lo_ref;
    @(negedge clk);
    lo_ref = lo;
    start = 1'b1;
    op    = v_op;
    sign  = v_sign;
    a     = v_a;
    b     = v_b;
    @(negedge clk);
    start    = 1'b0;
    done_cyc = 0;
    done_cnt = 0;
    busy_cnt = 0;
    cap_hi   = '0;
    cap_lo   = '0;
    cap_dz   = 1'b0;
    for (int cyc = 1; cyc <= WINDOW; cyc++) begin
      if (cyc == x_start) begin
        start = 1'b1;
        op    = 1'b1;
        sign  = 1'b0;
        a     = 32'd100;
        b     = 32'd7;
      end else begin
        start = 1'b0;
      end
      if (cyc == wrlo_cyc) begin
        wr_lo = 1'b1;
        wdata = 32'hDEADBEEF;
      end else begin
        wr_lo = 1'b0;
      end
      if (wrlo_cyc != 0 && cyc == wrlo_cyc + 1) begin
        chk("lo_unchanged_by_mtlo_in_run", lo, lo_ref);
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = cyc;
          cap_hi   = hi;
          cap_lo   = lo;
          cap_dz   = div_zero;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    wr_lo = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    start  = 1'b0;
    op     = 1'b0;
    sign   = 1'b0;
    a      = '0;
    b      = '0;
    wr_hi  = 1'b0;
    wr_lo  = 1'b0;
    wdata  = '0;
    rst_n  = 1'b0;

    //        op    sign  a             b             exp_hi        exp_lo        dz
    vecs[0]  = '{1'b0, 1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};

    // Reset values while reset is held
    repeat (2) @(negedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_dz",   32'(div_zero), 32'd0);
    chk("reset_hi",   hi, 32'd0);
    chk("reset_lo",   lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].sign, vecs[i].a, vecs[i].b, 0, 0);
      chk($sformatf("v%0d_done_cycle", i), 32'(done_cyc), vecs[i].exp_dz ? 32'd1 : 32'(N + 2));
      chk($sformatf("v%0d_done_count", i), 32'(done_cnt), 32'd1);
      chk($sformatf("v%0d_busy_cycles", i), 32'(busy_cnt), vecs[i].exp_dz ? 32'd0 : 32'(N + 1));
      chk($sformatf("v%0d_hi", i), cap_hi, vecs[i].exp_hi);
      chk($sformatf("v%0d_lo", i), cap_lo, vecs[i].exp_lo);
      chk($sformatf("v%0d_div_zero", i), 32'(cap_dz), 32'(vecs[i].exp_dz));
      if (vecs[i].exp_dz) begin
        chk($sformatf("v%0d_dz_held", i), 32'(div_zero), 32'd1);
      end
    end

    // MTHI in IDLE
    @(negedge clk);
    wr_hi = 1'b1;
    wdata = 32'hA5A5A5A5;
    @(negedge clk);
    wr_hi = 1'b0;
    chk("mthi_idle", hi, 32'hA5A5A5A5);

    // MTLO in IDLE
    wr_lo = 1'b1;
    wdata = 32'h5A5A5A5A;
    @(negedge clk);
    wr_lo = 1'b0;
    chk("mtlo_idle", lo, 32'h5A5A5A5A);

    // Start together with MTHI: start wins, write dropped
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    sign  = 1'b0;
    a     = 32'd6;
    b     = 32'd7;
    wr_hi = 1'b1;
    wdata = 32'h11111111;
    @(negedge clk);
    start = 1'b0;
    wr_hi = 1'b0;
    chk("start_beats_mthi", hi, 32'hA5A5A5A5);
    repeat (N + 1) @(negedge clk);
    chk("start_beats_mthi_done", 32'(done), 32'd1);
    chk("start_beats_mthi_hi", hi, 32'd0);
    chk("start_beats_mthi_lo", lo, 32'd42);

    // Second start in cycle 10 is ignored; MTLO during RUN is ignored
    run_op(1'b0, 1'b0, 32'd3, 32'd5, 10, 5);
    chk("restart_done_count", 32'(done_cnt), 32'd1);
    chk("restart_done_cycle", 32'(done_cyc), 32'(N + 2));
    chk("restart_hi", cap_hi, 32'd0);
    chk("restart_lo", cap_lo, 32'd15);

    // Reset in cycle 15 of a divide
    @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    sign  = 1'b0;
    a     = 32'd1000;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("midop_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midop_busy", 32'(busy), 32'd0);
    chk("midop_done", 32'(done), 32'd0);
    chk("midop_hi",   hi, 32'd0);
    chk("midop_lo",   lo, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int cyc = 0; cyc < WINDOW; cyc++) begin
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    chk("post_reset_no_done", 32'(done_cnt), 32'd0);
    chk("post_reset_no_busy", 32'(busy_cnt), 32'd0);
    chk("post_reset_hi", hi, 32'd0);

    // Unit still works after the abort
    run_op(1'b1, 1'b0, 32'd1000, 32'd3, 0, 0);
    chk("after_abort_done_cycle", 32'(done_cyc), 32'(N + 2));
    chk("after_abort_hi", cap_hi, 32'd1);
    chk("after_abort_lo", cap_lo, 32'd333);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multi-cycle multiply/divide unit that produces the HI/LO register pair for MULT/MULTU/DIV/DIVU and serves them to the execute stage for MFHI/MFLO. It sits beside the ALU in the execute stage and takes over the HI/LO ownership that the single-cycle ALU cannot provide. The controller issues a one-cycle `start` and stalls on `busy`. Results land in HI/LO together with a one-cycle `done` pulse.

## Interface
- `N`, 32, operand/result width; also the iteration count.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  1  0 = multiply, 1 = divide.
- `sign`  in  1  1 = signed (two's complement), 0 = unsigned.
- `a`, `b`  in  N  operands, sampled on the accepting edge only.
- `wr_hi`, `wr_lo`  in  1  MTHI/MTLO write strobes.
- `wdata`  in  N  MTHI/MTLO data.
- `busy`  out  1  operation in flight; the controller stalls the pipeline.
- `done`  out  1  one-cycle pulse; HI/LO are valid and updated this cycle.
- `div_zero`  out  1  set with `done` when the divide had b == 0; held until the next accepted start.
- `hi`, `lo`  out  N  architectural HI/LO registers.

## Operation
- States are IDLE, RUN, FIX.
- **IDLE**
  - If `start` is asserted, latch op and sign, plus |a|, |b| and the result sign flags.
  - Magnitude means negate if `sign` is set and the MSB is 1.
- **IDLE to RUN**
  - Taken when `start` is asserted and this is not a divide with b == 0. Counter is cleared to 0.
- **Divide with b == 0**
  - Stay in IDLE.
  - Next edge: `hi` = a, `lo` = all ones, `div_zero` = 1, `done` = 1.
- **Multiply, RUN**
  - Radix-2 shift-add: 2N-bit accumulator.
  - Each cycle, if multiplier LSB = 1 add the multiplicand into the upper half, then shift right by 1.
- **Divide, RUN**
  - Restoring algorithm: N-bit remainder plus N-bit quotient shift register.
  - One quotient bit per cycle.
- **RUN to FIX**
  - Taken after exactly N RUN cycles (counter reaches N-1).
- **FIX (1 cycle)**
  - Apply sign correction.
  - Multiply: negate the 2N-bit product if sign_a ^ sign_b.
  - Divide: negate the quotient if sign_a ^ sign_b; the remainder takes the dividend's sign.
  - Write `hi` (product upper half, or remainder) and `lo` (product lower half, or quotient). Pulse `done`, clear `div_zero`, return to IDLE.
- **Signed overflow**
  - -2^31 / -1 gives `lo` = 0x80000000, `hi` = 0, no flag.
- **MTHI/MTLO**
  - `wr_hi`/`wr_lo` write `wdata` at the edge, only in IDLE.
  - They are ignored while busy.
  - If asserted in the same cycle as an accepted `start`, `start` wins and the write is dropped.
- **Start while not in IDLE**
  - `start` is ignored; no queueing.
- **Arithmetic width**
  - All arithmetic is modulo its stated width; there is no saturation.

## Timing
- Reset values (asynchronous, immediate on `rst_n` = 0): state IDLE, `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `div_zero` = 0, counter = 0.
- Reset mid-operation aborts the operation; no partial result reaches HI/LO.
- Cycle 0 is the cycle in which `start` is sampled high in IDLE.
- **Normal op**
  - `busy` = 1 in cycles 1..N+1 (RUN and FIX).
  - `done` = 1 and new `hi`/`lo` visible in cycle N+2.
  - `busy` = 0 in cycle N+2, so a new `start` is accepted in cycle N+2.
- **Divide by zero**
  - `done` and `div_zero` in cycle 1; `busy` is never asserted.
- `done` is registered and lasts exactly one cycle.
- `hi`/`lo` change only on a `done` edge or an MTHI/MTLO write.
- `busy` is registered and is a pure function of state (RUN or FIX).

## Test plan
- Signed multiply: op=0, sign=1, a=-3, b=5. Require `done` in cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Unsigned multiply: a=0xFFFFFFFF, b=2. Require hi=0x00000001, lo=0xFFFFFFFE. Repeat with sign=1: require hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- Signed divide: a=-7, b=2. Require lo=0xFFFFFFFD, hi=0xFFFFFFFF. Unsigned divide: a=100, b=7. Require lo=14, hi=2.
- Divide by zero: a=0x1234, b=0. Require `done` and `div_zero` in cycle 1, hi=0x1234, lo=0xFFFFFFFF, `busy` never high. A following valid start must clear `div_zero`.
- Start plus write contention:
  - Pulse `start` again in cycle 10 of a multiply: require the second start is ignored and a single `done`.
  - Assert `wr_lo` during RUN: require `lo` is unchanged.
  - Assert `wr_hi` with wdata=0xA5A5A5A5 in IDLE: require hi=0xA5A5A5A5 in the next cycle.
- Reset mid-op: deassert `rst_n` in cycle 15 of a divide. Require immediate busy=0, done=0, hi=lo=0. After release, no `done` until a new start.
